// File: rtl/vec_eng_pkg.sv
// Shared vector-engine definitions.
//   bf16_t           : bfloat16 word (sign 1, exponent 8, fraction 7)
//   INVSQRT_PIPE_LAT : cycles from operand valid to result valid of the
//                      shared inverse-square-root pipe
package vec_eng_pkg;

    typedef logic [15:0] bf16_t;

    localparam int INVSQRT_PIPE_LAT = 17;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, one bit per requester
//   ack        : the current grant was consumed this cycle
//   gnt        : one-hot grant (zero when no request is pending)
//   gnt_idx    : binary index of the granted requester
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       ack,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic [TAG_W-1:0] rr_ptr;

    // Search upward from the pointer with wrap-around; the first pending
    // request found wins. Depends only on req and rr_ptr.
    always_comb begin
        int  cand;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = TAG_W'(cand);
            end
        end
    end

    // After a consumed grant, priority moves to the requester just past the
    // winner; the explicit wrap keeps non-power-of-two counts correct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (ack) begin
            if (gnt_idx == TAG_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_idx + TAG_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_invsqrt_arb.sv
// Shares one bfloat16 inverse-square-root pipe between NUM_REQ requesters.
// Operands are tagged with their requester index, the tag rides a delay line
// matched to the pipe latency, and each result is strobed back to its owner.
//   clk, rst_n : clock, asynchronous active-low reset (also resets the pipe)
//   req_x      : NUM_REQ packed bfloat16 operands, requester i at [16*i +: 16]
//   req_vld    : operand valid per requester
//   req_rdy    : one-hot grant (zero when nothing pending)
//   pipe_x     : operand to the pipe;   pipe_x_vld : its valid
//   pipe_y     : result from the pipe;  pipe_y_vld : its valid
//   rsp_y      : result broadcast to all requesters
//   rsp_vld    : one-hot result strobe
//   lat_err    : sticky flag, pipe result valid disagreed with the tag line
module fp_invsqrt_arb
    import vec_eng_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = INVSQRT_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ*16-1:0] req_x,
    input  logic [NUM_REQ-1:0]    req_vld,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic [15:0]           pipe_x,
    output logic                  pipe_x_vld,
    input  logic [15:0]           pipe_y,
    input  logic                  pipe_y_vld,
    output logic [15:0]           rsp_y,
    output logic [NUM_REQ-1:0]    rsp_vld,
    output logic                  lat_err
);

    localparam int TAG_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [TAG_W-1:0]   gnt_idx;
    logic               hs;

    // Entry 0 is loaded alongside pipe_x_vld, so entry PIPE_LAT lines up
    // with pipe_y_vld of a pipe with PIPE_LAT cycles of latency.
    logic               tag_vld [0:PIPE_LAT];
    logic [TAG_W-1:0]   tag_idx [0:PIPE_LAT];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vld),
        .ack     (hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The arbiter only grants pending requesters, so any grant is a handshake.
    assign req_rdy = gnt;
    assign hs      = |gnt;

    // Issue register, tag delay line, response register and error flag all
    // advance together every cycle; there is no stall anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_x     <= '0;
            pipe_x_vld <= 1'b0;
            rsp_y      <= '0;
            rsp_vld    <= '0;
            lat_err    <= 1'b0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_idx[k] <= '0;
            end
        end else begin
            pipe_x_vld <= hs;
            tag_vld[0] <= hs;
            if (hs) begin
                pipe_x     <= req_x[16*gnt_idx +: 16];
                tag_idx[0] <= gnt_idx;
            end
            for (int k = 1; k <= PIPE_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
            // The strobe comes from the tag line only, so a misbehaving pipe
            // can corrupt data but never misroute a response.
            if (tag_vld[PIPE_LAT]) begin
                rsp_y   <= pipe_y;
                rsp_vld <= NUM_REQ'(1) << tag_idx[PIPE_LAT];
            end else begin
                rsp_vld <= '0;
            end
            if (pipe_y_vld != tag_vld[PIPE_LAT]) begin
                lat_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_invsqrt_arb.sv
// Self-checking bench for fp_invsqrt_arb: per-requester operand queues drive
// the arbiter, a round-robin reference predicts every grant, expected results
// go into a scoreboard, and a monitor pops it on each response strobe.
module tb_fp_invsqrt_arb;

    localparam int N    = 4;
    localparam int L    = 17;
    localparam int RESP = L + 2;

    logic            clk;
    logic            rst_n;
    logic [N*16-1:0] req_x;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [15:0]     pipe_x;
    logic            pipe_x_vld;
    logic [15:0]     pipe_y;
    logic            pipe_y_vld;
    logic [15:0]     rsp_y;
    logic [N-1:0]    rsp_vld;
    logic            lat_err;

    typedef struct {
        int          idx;
        logic [15:0] x;
        int          due;
        bit          chk_val;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] rq [N][$];
    int          rr_model;
    bit          chk_val;
    int          cyc;
    int          n_checks;
    int          n_fails;
    int          pipe_lat;

    logic        pm_vld [0:31];
    logic [15:0] pm_dat [0:31];

    fp_invsqrt_arb #(
        .NUM_REQ  (N),
        .PIPE_LAT (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_x      (req_x),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .pipe_x     (pipe_x),
        .pipe_x_vld (pipe_x_vld),
        .pipe_y     (pipe_y),
        .pipe_y_vld (pipe_y_vld),
        .rsp_y      (rsp_y),
        .rsp_vld    (rsp_vld),
        .lat_err    (lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bfloat16 helpers for positive normal numbers
    function automatic real bf16_to_real(logic [15:0] b);
        real m;
        int  e;
        m = 1.0 + real'(b[6:0]) / 128.0;
        e = int'(b[14:7]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return m;
    endfunction

    function automatic logic [15:0] real_to_bf16(real v);
        int          e;
        int          f;
        logic [15:0] r;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        f = int'((v - 1.0) * 128.0);
        if (f >= 128) begin f = 0; e++; end
        r = {1'b0, e[7:0], f[6:0]};
        return r;
    endfunction

    function automatic logic [15:0] invsqrt_bf16(logic [15:0] x);
        if (x[14:7] == 8'd0) return 16'h0000;
        return real_to_bf16(1.0 / $sqrt(bf16_to_real(x)));
    endfunction

    // Behavioural model of the external pipe with a selectable latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                pm_vld[k] <= 1'b0;
                pm_dat[k] <= 16'h0000;
            end
        end else begin
            pm_vld[0] <= pipe_x_vld;
            pm_dat[0] <= invsqrt_bf16(pipe_x);
            for (int k = 1; k < 32; k++) begin
                pm_vld[k] <= pm_vld[k-1];
                pm_dat[k] <= pm_dat[k-1];
            end
        end
    end

    always_comb begin
        pipe_y_vld = pm_vld[pipe_lat-1];
        pipe_y     = pm_dat[pipe_lat-1];
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus: present queue heads, predict the winner, compare
    // the grant and record the expected response for the winner.
    task automatic applyStimulus(output int g);
        int c;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_vld[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) req_x[16*i +: 16] = rq[i][0];
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            c = (rr_model + k) % N;
            if (g < 0 && rq[c].size() > 0) g = c;
        end
        checkOutput("req_rdy", 32'(req_rdy), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            sb.push_back('{idx: g, x: rq[g][0], due: cyc + RESP, chk_val: chk_val});
            void'(rq[g].pop_front());
            rr_model = (g + 1) % N;
        end
    endtask

    task automatic runCycles(int n);
        int g;
        repeat (n) applyStimulus(g);
    endtask

    task automatic drain();
        int g;
        int budget;
        budget = 0;
        while ((sb.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 ||
                rq[2].size() > 0 || rq[3].size() > 0) && budget < 600) begin
            applyStimulus(g);
            budget++;
        end
        n_checks++;
        if (sb.size() > 0) begin
            n_fails++;
            $display("[TB] FAIL drain_timeout: %0d responses still outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Reset lands 2ns after a falling edge so the monitor has already sampled
    // that cycle's outputs; in-flight expectations are dropped with it.
    task automatic applyReset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        req_vld = '0;
        sb.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
        rr_model = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Response monitor
    initial begin
        exp_t e;
        real  want;
        real  got;
        real  rel;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL rsp_missing: requester %0d response due cycle %0d not seen by cycle %0d", e.idx, e.due, cyc);
                end
                if (rsp_vld != '0) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("[TB] FAIL rsp_unexpected: rsp_vld=0x%0h at cycle %0d, expected no strobe", rsp_vld, cyc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("rsp_vld", 32'(rsp_vld), 32'd1 << e.idx);
                        checkOutput("rsp_cycle", cyc, e.due);
                        if (e.chk_val) begin
                            want = 1.0 / $sqrt(bf16_to_real(e.x));
                            got  = (rsp_y[14:7] == 8'd0) ? 0.0 : bf16_to_real(rsp_y);
                            rel  = (got - want) / want;
                            if (rel < 0.0) rel = -rel;
                            n_checks++;
                            if (rel > 1.0e-2) begin
                                n_fails++;
                                $display("[TB] FAIL rsp_y for x=0x%0h: got %f (0x%0h), expected %f", e.x, got, rsp_y, want);
                            end
                        end
                    end
                end
            end
        end
    end

    // Safety net against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          g;
        int          first3;
        int          t_issue;
        int          issued;
        int          r;
        int          glog [$];
        logic [15:0] ops [4];
        real         v;

        ops[0] = 16'h3F80; ops[1] = 16'h4080; ops[2] = 16'h4180; ops[3] = 16'h42C8;
        cyc = 0; n_checks = 0; n_fails = 0; pipe_lat = L;
        rr_model = 0; chk_val = 1'b1;
        rst_n = 1'b0; req_vld = '0; req_x = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_pipe_x_vld", 32'(pipe_x_vld), 32'd0);
        checkOutput("reset_pipe_x", 32'(pipe_x), 32'd0);
        checkOutput("reset_rsp_vld", 32'(rsp_vld), 32'd0);
        checkOutput("reset_rsp_y", 32'(rsp_y), 32'd0);
        checkOutput("reset_lat_err", 32'(lat_err), 32'd0);
        checkOutput("reset_req_rdy", 32'(req_rdy), 32'd0);
        #1;
        rst_n = 1'b1;

        // Single request from requester 2
        $display("[TB] single request");
        rq[2].push_back(16'h4080);
        drain();
        runCycles(5);

        // Full contention, starting from a fresh pointer
        $display("[TB] full contention");
        applyReset();
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++) rq[i].push_back(ops[i]);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(g);
            glog.push_back(g);
        end
        for (int c = 0; c < 8; c++) checkOutput("contention_order", glog[c], c % N);
        drain();

        // Fairness: requester 0 always valid, requester 3 joins at cycle 5
        $display("[TB] fairness");
        first3 = -1;
        for (int i = 0; i < 16; i++) rq[0].push_back(16'h4100);
        for (int c = 0; c < 14; c++) begin
            if (c == 5) for (int i = 0; i < 4; i++) rq[3].push_back(16'h4200);
            applyStimulus(g);
            if (g == 3 && first3 < 0) first3 = c;
        end
        checkOutput("fairness_wait_ok", 32'((first3 >= 5) && (first3 - 5 < N)), 32'd1);
        drain();

        // Random soak
        $display("[TB] random soak");
        issued = 0;
        while (issued < 100) begin
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, N - 1);
                v = 1.0 + real'($urandom_range(0, 399 * 16)) / 16.0;
                rq[r].push_back(real_to_bf16(v));
                issued++;
            end
            applyStimulus(g);
        end
        drain();
        checkOutput("soak_lat_err", 32'(lat_err), 32'd0);

        // Mid-flight reset
        $display("[TB] mid-flight reset");
        for (int i = 0; i < 10; i++) rq[(i + 1) % N].push_back(16'h4000 + 16'(i));
        runCycles(12);
        applyReset();
        runCycles(25);
        for (int i = 0; i < N; i++) rq[i].push_back(16'h3F80);
        applyStimulus(g);
        checkOutput("post_reset_first_grant", g, 0);
        drain();

        // Latency mismatch: pipe one cycle too short
        $display("[TB] latency mismatch");
        applyReset();
        pipe_lat = 16;
        chk_val  = 1'b0;
        t_issue  = -1;
        rq[1].push_back(16'h4080);
        for (int c = 0; c < 26; c++) begin
            applyStimulus(g);
            if (g >= 0) t_issue = cyc;
            checkOutput("lat_err", 32'(lat_err), 32'((t_issue >= 0) && (cyc >= t_issue + L + 1)));
        end
        drain();
        checkOutput("lat_err_sticky", 32'(lat_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fp_invsqrt_arb.md
# fp_invsqrt_arb

Round-robin arbiter that shares one bfloat16 inverse-square-root pipeline (`fp_invsqrt_pipe`) between `NUM_REQ` requesters, such as per-head RMSnorm lanes in the vector engine. It accepts one operand per cycle, tags each operand with its requester index, and carries that tag down a delay line matched to the pipe latency. Each result is returned to its originator. It also cross-checks the pipe's `y_vld` against the tag line and flags any latency mismatch.

## Interface
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `PIPE_LAT`, 17: cycles from `pipe_x_vld` to `pipe_y_vld` of the attached pipe.
- `TAG_W`, `$clog2(NUM_REQ)`: requester index width; derived, do not override.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset; the same net resets the attached pipe.
- `req_x`  in  `NUM_REQ`×16  bfloat16 operand per requester (sign 1, exp 8, frac 7).
- `req_vld`  in  `NUM_REQ`  operand valid per requester.
- `req_rdy`  out  `NUM_REQ`  grant, one-hot or zero.
- `pipe_x`  out  16  operand to the pipe.
- `pipe_x_vld`  out  1  operand valid to the pipe.
- `pipe_y`  in  16  pipe result.
- `pipe_y_vld`  in  1  pipe result valid.
- `rsp_y`  out  16  result, broadcast to all requesters.
- `rsp_vld`  out  `NUM_REQ`  one-hot result strobe.
- `lat_err`  out  1  sticky latency-mismatch flag.

## Operation
- **Arbitration:**
  - Combinational round-robin over `req_vld`, starting at pointer `rr_ptr`.
  - `req_rdy[i]` is 1 only for the single granted requester, and only when `req_vld[i]` is 1.
  - A handshake happens when `req_vld[i] && req_rdy[i]`.
- **Pointer update:** after a grant to index g, `rr_ptr` becomes (g+1) mod `NUM_REQ`. `rr_ptr` is unchanged when nothing is granted.
- **Issue register:** on a handshake, `pipe_x` ← `req_x[g]`, `pipe_x_vld` ← 1, and `tag_sr[0]` ← {1, g}. With no handshake, `pipe_x_vld` ← 0 and the valid bit of `tag_sr[0]` ← 0. `pipe_x` holds its last value.
- **Tag line:** `PIPE_LAT` stages of {valid, tag}. Entry k+1 ← entry k every cycle, with no stall.
- **Response register:**
  - `rsp_y` ← `pipe_y` whenever the last tag stage is valid.
  - `rsp_vld` ← one-hot(tag) when that stage is valid, otherwise 0.
- **Latency check:** if `pipe_y_vld` ≠ valid bit of the last tag stage in any cycle, set `lat_err` ← 1. It stays 1 until reset. `rsp_vld` is always driven from the tag line, never from `pipe_y_vld`.
- **Backpressure:** the block has no response backpressure. Requesters must sink `rsp_vld` on every cycle.
- **Throughput:** one operand per cycle total. A requester held valid alone is granted every cycle. With all `NUM_REQ` valid, each is granted once per `NUM_REQ` cycles.
- **Reset values:** `rr_ptr`=0, all tag-line valids=0, `pipe_x_vld`=0, `pipe_x`=0, `rsp_vld`=0, `rsp_y`=0, `lat_err`=0.
- **Reset mid-operation:** all in-flight operands are dropped and no `rsp_vld` fires for them. Arbitration restarts at index 0.
- **Simultaneous requests:** the first valid index at or after `rr_ptr` wins; the rest see `req_rdy`=0 and must hold their operand.

## Timing
- **Handshake to issue:** 1 cycle; the handshake in cycle t gives `pipe_x_vld`=1 in t+1.
- **Handshake to response:** `rsp_vld` one-hot in cycle t+1+`PIPE_LAT`+1 = t+`PIPE_LAT`+2, which is 19 at defaults.
- **Ordering:** results return in issue order, back to back, with no gaps introduced by the arbiter.
- **Combinational path:** `req_rdy` depends combinationally on `req_vld` and `rr_ptr` only. There is no combinational path from `pipe_*` to any output.
- **Latency check timing:** `lat_err` rises the cycle after the first mismatch.

## Structure
- **Shared package:** the `vec_eng_pkg` bfloat16 typedef (`bf16_t`, 16 bits) and a `INVSQRT_PIPE_LAT = 17` constant. `PIPE_LAT` defaults to that constant.
- **Sub-module `rr_arbiter`:** parameterised `NUM_REQ`. Inputs `clk`, `rst_n`, `req`, `ack`; outputs one-hot `gnt` and `gnt_idx`. It holds `rr_ptr` internally.
- **Top block:** `fp_invsqrt_arb` holds the issue register, the tag shift line, the response register and the error flag. The pipe sits outside the block and is wired at the RMSnorm level.

## Test plan
- **Single request:** requester 2 sends `req_x`=0x4080 (4.0) for one cycle → `rsp_vld`=4'b0100 exactly 19 cycles later; `rsp_y` within 1e-2 relative of 0.5 (0x3F00). No other strobes fire.
- **Full contention:** all four requesters valid for 8 cycles with operands 0x3F80, 0x4080, 0x4180, 0x42C8 (1, 4, 16, 100) → grants in order 0,1,2,3,0,1,2,3. Responses in the same order, tolerance 1%, values about 1.0, 0.5, 0.25, 0.1.
- **Fairness:** requester 0 held valid continuously and requester 3 raised at cycle 5 → requester 3 is granted within `NUM_REQ` cycles and alternates with 0 thereafter.
- **Random soak:** 100 random operands in [1, 400] on random requesters → every result reaches the correct requester, error < 1e-2, and `lat_err` stays 0.
- **Mid-flight reset:** assert `rst_n`=0 for 2 cycles while 10 operands are in flight → no `rsp_vld` afterward, and the first post-reset grant goes to index 0.
- **Latency mismatch:** attach a pipe model with latency 16 → `lat_err`=1 one cycle after the first early `pipe_y_vld`, and it stays set.
